// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//   Operand/result bundle for nibble_serial_adder.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : adder side (drives in_ready, result and status)
//   Signals: in_valid/in_ready/a/b/cin (operand handshake),
//            out_valid/out_ready/sum/cout (result handshake), busy.
//   With NIBBLE_SERIAL_ADDER_SUB_EN defined, a 'sub' select travels
//   with the operands.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   WIDTH-bit adder that streams operands through a single 4-bit
//   carry-lookahead cell, one nibble per clock, LS nibble first, with the
//   carry registered between nibbles. Result is offered on a valid/ready
//   port once all WIDTH/4 nibbles are done.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : nibble_serial_adder_if.slave
//           in_valid/in_ready/a/b/cin  operand handshake (in_ready only in IDLE)
//           out_valid/out_ready/sum/cout result handshake (registered)
//           busy                        high while RUN or DONE
// Build option:
//   NIBBLE_SERIAL_ADDER_SUB_EN adds bus.sub; sub=1 computes a - b
//   (cout=1 means no borrow). Undefined: add only.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       cell_s;
  logic             cell_co;
  logic             last_nib;

  // Operand B and initial carry as they are captured on acceptance.
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  // Two's complement subtract: a + ~b + 1; cin is deliberately ignored.
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  // Select the nibble pair for the current index.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (idx == IDXW'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
  end

  assign last_nib = (idx == IDXW'(NIB - 1));

  cla_4bit u_cell (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is exactly (state == IDLE), so in_valid alone accepts.
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= b_load;
            carry <= c_load;
            idx   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          for (int unsigned n = 0; n < NIB; n++) begin
            if (idx == IDXW'(n)) begin
              sum_q[4*n +: 4] <= cell_s;
            end
          end
          carry <= cell_co;
          if (last_nib) begin
            cout_q      <= cell_co;
            out_valid_q <= 1'b1;
            idx         <= '0;
            state       <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          idx         <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// cla_4bit
//   4-bit carry-lookahead adder cell: s = a + b + cin (low 4 bits),
//   cout = carry out of bit 3. All carries formed from generate/propagate
//   terms directly rather than rippled.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Directed bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
//   Expected {cout,sum} values come from an arithmetic model and are queued
//   on acceptance; a monitor per instance pops them on each output handshake.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned checks;
  int unsigned passes;

  logic [16:0] q16[$];
  logic [4:0]  q4[$];

  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  nibble_serial_adder #(.WIDTH(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: {cout,sum} = a + b' + c' over w bits, where sub selects
  // b' = ~b and c' = 1.
  function automatic logic [16:0] model(input int unsigned w, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin,
                                        input logic sub);
    logic [31:0] mask;
    logic [31:0] bb;
    logic [31:0] r;
    mask = (32'd1 << w) - 32'd1;
    bb   = sub ? (~{16'h0, b} & mask) : ({16'h0, b} & mask);
    r    = ({16'h0, a} & mask) + bb + (sub ? 32'd1 : {31'd0, cin});
    r    = r & ((32'd1 << (w + 1)) - 32'd1);
    return r[16:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus16.out_valid && bus16.out_ready) begin
      if (q16.size() == 0) chk("spurious_out16", bus16.out_valid, 0);
      else begin
        logic [16:0] e;
        e = q16.pop_front();
        chk("sum16", bus16.sum, e[15:0]);
        chk("cout16", bus16.cout, e[16]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (q4.size() == 0) chk("spurious_out4", bus4.out_valid, 0);
      else begin
        logic [4:0] e;
        e = q4.pop_front();
        chk("sum4", bus4.sum, e[3:0]);
        chk("cout4", bus4.cout, e[4]);
      end
    end
  end

  // All helpers are entered and left 1 time unit after a rising edge.
  task automatic send(input bit w4, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input bit push,
                      input bit hold, output int unsigned acc);
    bit ok;
    ok = 1'b0;
    if (w4) begin
      bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.cin = cin; bus4.in_valid = 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      bus4.sub = sub;
`endif
    end else begin
      bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.in_valid = 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      bus16.sub = sub;
`endif
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (w4 ? bus4.in_ready : bus16.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", w4 ? bus4.in_ready : bus16.in_ready, 1);
    else if (push) begin
      if (w4) q4.push_back(model(4, a, b, cin, sub) & 17'h1F);
      else    q16.push_back(model(16, a, b, cin, sub));
    end
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) begin
      bus16.in_valid = 1'b0;
      bus4.in_valid  = 1'b0;
    end
  endtask

  task automatic wait_ov(input bit w4, output int unsigned t);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (w4 ? bus4.out_valid : bus16.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("out_valid_timeout", w4 ? bus4.out_valid : bus16.out_valid, 1);
    t = cyc;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q16.size() == 0 && q4.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", q16.size() + q4.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned acc1;
    int unsigned acc2;
    int unsigned t;
    int unsigned c0;
    logic [16:0] ex;

    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.out_ready  = 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    bus16.sub = 1'b0;
    bus4.sub  = 1'b0;
`endif

    // Reset state, with in_valid asserted to show it is ignored in reset.
    repeat (2) @(posedge clk);
    #1 bus16.in_valid = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", bus16.out_valid, 0);
    chk("rst_busy", bus16.busy, 0);
    chk("rst_in_ready", bus16.in_ready, 1);
    chk("rst_sum", bus16.sum, 0);
    chk("rst_cout", bus16.cout, 0);
    chk("rst_out_valid4", bus4.out_valid, 0);
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    rst_n = 1'b1;

    // Full carry ripple across all nibbles.
    send(0, 16'hFFFF, 16'h0001, 0, 0, 1, 0, acc1);
    wait_ov(0, t);
    chk("latency16", t - acc1, 4);
    @(negedge clk);
    chk("pulse16_out_valid", bus16.out_valid, 0);
    chk("pulse16_in_ready", bus16.in_ready, 1);
    @(posedge clk); #1;

    // Carry-in, then back-to-back with in_valid held and operands changed
    // right after the first acceptance.
    send(0, 16'h1234, 16'h4321, 1, 0, 1, 1, acc1);
    chk("run_busy", bus16.busy, 1);
    chk("run_in_ready", bus16.in_ready, 0);
    send(0, 16'h0F0F, 16'h00F1, 0, 0, 1, 0, acc2);
    chk("throughput", acc2 - acc1, 6);
    wait_drain();

    // Backpressure with new operands waiting.
    bus16.out_ready = 1'b0;
    send(0, 16'h7FFF, 16'h7FFF, 1, 0, 1, 0, acc1);
    wait_ov(0, t);
    ex = model(16, 16'h7FFF, 16'h7FFF, 1, 0);
    bus16.a = 16'h0001; bus16.b = 16'h0002; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus16.out_valid, 1);
      chk("bp_in_ready", bus16.in_ready, 0);
      chk("bp_sum", bus16.sum, ex[15:0]);
      chk("bp_cout", bus16.cout, ex[16]);
    end
    @(posedge clk); #1;
    bus16.out_ready = 1'b1;
    c0 = cyc;
    send(0, 16'h0001, 16'h0002, 0, 0, 1, 0, acc2);
    chk("bp_accept_cycle", acc2 - c0, 2);
    wait_drain();

    // Reset while the nibble index is 2; no result may ever appear.
    send(0, 16'h1111, 16'h2222, 0, 0, 0, 0, acc1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", bus16.out_valid, 0);
    chk("midrst_busy", bus16.busy, 0);
    chk("midrst_in_ready", bus16.in_ready, 1);
    chk("midrst_sum", bus16.sum, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_result", bus16.out_valid, 0);

    // Single-nibble instance.
    send(1, 16'h000F, 16'h000F, 1, 0, 1, 0, acc1);
    wait_ov(1, t);
    chk("latency4", t - acc1, 1);
    send(1, 16'h0008, 16'h0007, 0, 0, 1, 0, acc1);
    wait_drain();

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    // Subtract; cin=1 on the first one must be ignored.
    send(0, 16'h0005, 16'h0007, 1, 1, 1, 0, acc1);
    wait_drain();
    send(0, 16'h0007, 16'h0005, 0, 1, 1, 0, acc1);
    wait_drain();
    send(1, 16'h0003, 16'h0009, 0, 1, 1, 0, acc1);
    wait_drain();
`endif

    // Random operands on both widths.
    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      send(1'(i % 2), ra, rb, rc, rs, 1, 0, acc1);
      wait_drain();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
